// File: rtl/tb_wait_event.sv
// tb_wait_event: scenario wait-command handler (WAIT_CYCLES/WTR/WTF) pacing the line reader via ack; TB_WAIT_EVENT_LOG_EN enables tracing
module tb_wait_event #(
    parameter int ARGS_NB   = 5,
    parameter int WAIT_SIZE = 8,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  string                args [ARGS_NB],
    input  logic                 args_valid,
    input  logic [WAIT_SIZE-1:0] wait_signals,
    output logic                 ack,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [15:0]          err_cnt
);
    localparam int IW = WAIT_SIZE > 1 ? $clog2(WAIT_SIZE) : 1;

    typedef enum logic [2:0] {START, IDLE, WAIT_CYC, WAIT_EDGE, DONE} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q, tcnt_q;
    logic [IW-1:0]      idx_q;
    logic               rise_q, ack_q, timeout_err_q;
    logic [WAIT_SIZE-1:0] prev_q;
    logic [15:0]        err_cnt_q, err_cnt_d;
    logic [CNT_W:0]     arg1, arg2;
    logic               is_cyc, is_edge, is_rise, bad, accept, hit, expire, done;
    logic [CNT_W-1:0]   t_val;
    logic [16:0]        err_sum;

    // Unsigned decimal parse: {valid, value}; empty or non-digit strings are invalid, overflow truncates
    function automatic logic [CNT_W:0] parse_dec(input string s);
        logic             ok;
        logic [CNT_W-1:0] v;
        logic [7:0]       c;
        ok = s.len() > 0;
        v  = '0;
        for (int k = 0; k < s.len(); k++) begin
            c = s[k];
            if (c < 8'd48 || c > 8'd57) ok = 1'b0;
            else v = v * CNT_W'(10) + CNT_W'(c - 8'd48);
        end
        return {ok, v};
    endfunction

    // Command decode, edge detection and error accounting
    always_comb begin
        arg1      = parse_dec(args[1]);
        arg2      = parse_dec(args[2]);
        is_cyc    = args[0] == "WAIT_CYCLES";
        is_rise   = args[0] == "WTR";
        is_edge   = is_rise || args[0] == "WTF";
        t_val     = arg2[CNT_W] ? arg2[CNT_W-1:0] : '0;
        bad       = is_cyc  ? !arg1[CNT_W] :
                    is_edge ? (!arg1[CNT_W] || arg1[CNT_W-1:0] >= CNT_W'(WAIT_SIZE) ||
                               (args[2].len() != 0 && !arg2[CNT_W])) : 1'b0;
        accept    = args_valid && state_q == IDLE;
        hit       = rise_q ? (wait_signals[idx_q] & ~prev_q[idx_q]) : (~wait_signals[idx_q] & prev_q[idx_q]);
        expire    = state_q == WAIT_EDGE && !hit && tcnt_q == CNT_W'(1);
        done      = (state_q == WAIT_CYC && cnt_q == '0) || (state_q == WAIT_EDGE && (hit || expire));
        err_sum   = 17'(err_cnt_q) + 17'(args_valid && state_q != IDLE) + 17'(accept && bad) + 17'(expire);
        err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    // Command FSM with registered ack; completion always passes through DONE so ack never repeats back to back
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= START;
            cnt_q         <= '0;
            tcnt_q        <= '0;
            idx_q         <= '0;
            rise_q        <= 1'b0;
            prev_q        <= '0;
            ack_q         <= 1'b0;
            timeout_err_q <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            prev_q    <= wait_signals;
            err_cnt_q <= err_cnt_d;
            ack_q     <= 1'b0;
            if (expire) timeout_err_q <= 1'b1;
            case (state_q)
                START: begin
                    ack_q   <= 1'b1;
                    state_q <= DONE;
                end
                IDLE: if (args_valid) begin
                    if (is_cyc && !bad) begin
                        cnt_q   <= arg1[CNT_W-1:0];
                        state_q <= WAIT_CYC;
                    end else if (is_edge && !bad) begin
                        tcnt_q  <= t_val;
                        idx_q   <= arg1[IW-1:0];
                        rise_q  <= is_rise;
                        state_q <= WAIT_EDGE;
                    end else begin
                        ack_q   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                WAIT_CYC: if (done) begin
                    ack_q   <= 1'b1;
                    state_q <= DONE;
                end else cnt_q <= cnt_q - CNT_W'(1);
                WAIT_EDGE: if (done) begin
                    ack_q   <= 1'b1;
                    state_q <= DONE;
                end else if (tcnt_q != '0) tcnt_q <= tcnt_q - CNT_W'(1);
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack         = ack_q;
    assign busy        = state_q == WAIT_CYC || state_q == WAIT_EDGE;
    assign timeout_err = timeout_err_q;
    assign err_cnt     = err_cnt_q;

`ifdef TB_WAIT_EVENT_LOG_EN
    logic [CNT_W-1:0] elapsed_q;
    // Trace accepted commands, completions with elapsed cycles, and every error source
    always @(posedge clk) begin
        if (!rst_n) elapsed_q <= '0;
        else begin
            elapsed_q <= accept ? '0 : elapsed_q + CNT_W'(1);
            if (accept && !bad && (is_cyc || is_edge))
                $display("%0t tb_wait_event: accept %s %s %s", $time, args[0], args[1], args[2]);
            if (done)
                $display("%0t tb_wait_event: done after %0d cycles", $time, elapsed_q + CNT_W'(1));
            if (accept && bad)
                $display("%0t tb_wait_event: error bad_args %s %s %s", $time, args[0], args[1], args[2]);
            if (args_valid && state_q != IDLE)
                $display("%0t tb_wait_event: error protocol %s %s %s", $time, args[0], args[1], args[2]);
            if (expire)
                $display("%0t tb_wait_event: error timeout", $time);
        end
    end
`endif
endmodule

// File: tb/tb_tb_wait_event.sv
// tb_tb_wait_event: directed bench for the scenario wait-command handler
module tb_tb_wait_event;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    string       args [5];
    logic        args_valid = 1'b0;
    logic [7:0]  wait_signals = '0;
    logic        ack, busy, timeout_err;
    logic [15:0] err_cnt;
    int          passed = 0;
    int          total = 0;
    int          n, k, seen;

    tb_wait_event dut (
        .clk(clk), .rst_n(rst_n), .args(args), .args_valid(args_valid),
        .wait_signals(wait_signals), .ack(ack), .busy(busy),
        .timeout_err(timeout_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Present one line for a single cycle; returns at the negedge after the sampling edge
    task automatic send(input string a0, input string a1, input string a2);
        args[0] = a0; args[1] = a1; args[2] = a2; args[3] = ""; args[4] = "";
        args_valid = 1'b1;
        step();
        args_valid = 1'b0;
    endtask

    // Negedges elapsed until ack is seen high, bounded
    task automatic wait_ack(output int cnt);
        cnt = 0;
        while (ack !== 1'b1 && cnt < 300) begin
            step();
            cnt++;
        end
    endtask

    // Check ack latency, then that the pulse lasts exactly one cycle
    task automatic finish_cmd(input string tag, input int exp_n);
        int c;
        wait_ack(c);
        check({tag, "_lat"}, c, exp_n);
        step();
        check({tag, "_ack_low"}, {31'b0, ack}, 0);
    endtask

    initial begin
        foreach (args[i]) args[i] = "";
        step(); step();
        check("rst_ack", {31'b0, ack}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_terr", {31'b0, timeout_err}, 0);
        check("rst_err", {16'b0, err_cnt}, 0);
        rst_n = 1'b1;
        step();
        check("start_ack", {31'b0, ack}, 1);
        check("start_busy", {31'b0, busy}, 0);
        step();
        check("start_ack_low", {31'b0, ack}, 0);

        send("WAIT_CYCLES", "3", "");
        check("wc3_busy", {31'b0, busy}, 1);
        finish_cmd("wc3", 4);
        check("wc3_busy_low", {31'b0, busy}, 0);

        send("WAIT_CYCLES", "0", "");
        finish_cmd("wc0", 1);

        send("WTR", "2", "0");
        seen = 0;
        repeat (20) begin step(); seen |= int'(ack); end
        check("wtr_no_early_ack", seen, 0);
        check("wtr_busy", {31'b0, busy}, 1);
        wait_signals[2] = 1'b1;
        finish_cmd("wtr", 1);
        check("wtr_terr", {31'b0, timeout_err}, 0);

        send("WTF", "2", "0");
        repeat (5) step();
        wait_signals[2] = 1'b0;
        finish_cmd("wtf", 1);
        check("wtf_err", {16'b0, err_cnt}, 0);

        send("WTR", "5", "10");
        finish_cmd("wtr_to", 10);
        check("wtr_to_terr", {31'b0, timeout_err}, 1);
        check("wtr_to_err", {16'b0, err_cnt}, 1);

        send("WTR", "5", "10");
        repeat (9) step();
        wait_signals[5] = 1'b1;
        finish_cmd("edge_at_expiry", 1);
        check("edge_at_expiry_err", {16'b0, err_cnt}, 1);
        wait_signals[5] = 1'b0;
        step();

        send("WTR", "9", "0");
        finish_cmd("bad_idx", 0);
        check("bad_idx_err", {16'b0, err_cnt}, 2);

        send("SET", "X", "1");
        finish_cmd("other_cmd", 0);
        check("other_cmd_err", {16'b0, err_cnt}, 2);

        send("", "", "");
        finish_cmd("empty_line", 0);

        send("WAIT_CYCLES", "abc", "");
        finish_cmd("bad_num", 0);
        check("bad_num_err", {16'b0, err_cnt}, 3);

        send("WTF", "", "");
        finish_cmd("missing_idx", 0);
        check("missing_idx_err", {16'b0, err_cnt}, 4);

        send("WAIT_CYCLES", "100", "");
        k = 0;
        repeat (10) begin step(); k++; end
        args[0] = "WAIT_CYCLES"; args[1] = "1";
        args_valid = 1'b1;
        step(); k++;
        args_valid = 1'b0;
        check("proto_busy", {31'b0, busy}, 1);
        wait_ack(n);
        check("proto_lat", k + n, 101);
        check("proto_err", {16'b0, err_cnt}, 5);
        step();

        send("WAIT_CYCLES", "100", "");
        repeat (5) step();
        check("mid_busy", {31'b0, busy}, 1);
        rst_n = 1'b0;
        step();
        check("mid_rst_busy", {31'b0, busy}, 0);
        check("mid_rst_ack", {31'b0, ack}, 0);
        check("mid_rst_terr", {31'b0, timeout_err}, 0);
        check("mid_rst_err", {16'b0, err_cnt}, 0);
        rst_n = 1'b1;
        step();
        check("restart_ack", {31'b0, ack}, 1);
        step();
        check("restart_ack_low", {31'b0, ack}, 0);

        send("WTF", "0", "1");
        finish_cmd("wtf_t1", 1);
        check("wtf_t1_terr", {31'b0, timeout_err}, 1);
        check("wtf_t1_err", {16'b0, err_cnt}, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
